// File: rtl/sdcard_blkread.sv
// Block-read sequencer that masters the SD SPI engine register port: it polls for the
// data start token, streams one block into a byte buffer and checks the CRC16 residue.
module sdcard_blkread #(
   parameter int BLOCK_BYTES   = 512,
   parameter int TOKEN_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [0:1]  status,
   output logic        buf_we,
   output logic [0:9]  buf_adr,
   output logic [0:7]  buf_d,
   output logic [0:3]  sd_adr,
   output logic        sd_cs,
   output logic [0:3]  sd_sel,
   output logic        sd_we,
   output logic [0:31] sd_d,
   input  logic [0:31] sd_q
);
   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_TCLR  = 4'd1,
      S_TXFER = 4'd2,
      S_TPOLL = 4'd3,
      S_DCLR  = 4'd4,
      S_DXFER = 4'd5,
      S_DPOLL = 4'd6,
      S_CXFER = 4'd7,
      S_CPOLL = 4'd8,
      S_CCHK  = 4'd9,
      S_FIN   = 4'd10
   } state_t;

   localparam logic [9:0]  LAST_IDX = 10'(BLOCK_BYTES - 1);
   localparam logic [16:0] TMO_LIM  = 17'(TOKEN_TIMEOUT);
   // Card CS kept asserted, engine busy set, MOSI = 0xFF, divider lane untouched.
   localparam logic [0:31] XFER_D   = 32'h0000_11FF;
   localparam logic [0:1]  ST_OK    = 2'b00;
   localparam logic [0:1]  ST_CRC   = 2'b01;
   localparam logic [0:1]  ST_TMO   = 2'b10;
   localparam logic [0:1]  ST_BAD   = 2'b11;

   state_t      r_state;
   state_t      w_next;
   logic [9:0]  r_idx;
   logic [15:0] r_cnt;
   logic        r_c;
   logic [0:1]  r_status;
   logic [0:1]  w_fin_st;
   logic        w_rdy;
   logic [7:0]  w_byte;
   logic [15:0] w_crc;
   logic        w_unused;

   assign w_rdy    = ~sd_q[23];
   assign w_byte   = sd_q[24:31];
   assign w_crc    = sd_q[16:31];
   assign w_unused = ^sd_q[0:15];
   assign status   = r_status;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state and completion-status selection; abort overrides everything.
   always_comb begin
      w_next   = r_state;
      w_fin_st = r_status;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_next = S_TCLR; else w_next = S_IDLE;
            S_TCLR:  w_next = S_TXFER;
            S_TXFER: w_next = S_TPOLL;
            S_TPOLL: begin
               if (!w_rdy) begin
                  w_next = S_TPOLL;
               end else if (w_byte == 8'hFE) begin
                  w_next = S_DCLR;
               end else if (w_byte == 8'hFF) begin
                  if (({1'b0, r_cnt} + 17'd1) < TMO_LIM) begin
                     w_next = S_TXFER;
                  end else begin
                     w_next   = S_FIN;
                     w_fin_st = ST_TMO;
                  end
               end else begin
                  w_next   = S_FIN;
                  w_fin_st = ST_BAD;
               end
            end
            S_DCLR:  w_next = S_DXFER;
            S_DXFER: w_next = S_DPOLL;
            S_DPOLL: begin
               if (!w_rdy)                 w_next = S_DPOLL;
               else if (r_idx == LAST_IDX) w_next = S_CXFER;
               else                        w_next = S_DXFER;
            end
            S_CXFER: w_next = S_CPOLL;
            S_CPOLL: begin
               if (!w_rdy)   w_next = S_CPOLL;
               else if (r_c) w_next = S_CCHK;
               else          w_next = S_CXFER;
            end
            S_CCHK: begin
               w_next = S_FIN;
               if (w_crc == 16'h0000) w_fin_st = ST_OK;
               else                   w_fin_st = ST_CRC;
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Byte index, token poll counter, CRC byte flag and latched status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_idx    <= 10'd0;
         r_cnt    <= 16'd0;
         r_c      <= 1'b0;
         r_status <= ST_OK;
      end else begin
         if (r_state == S_IDLE && w_next == S_TCLR) begin
            r_idx <= 10'd0;
            r_cnt <= 16'd0;
         end else if (r_state == S_TPOLL && w_next == S_TXFER) begin
            r_cnt <= r_cnt + 16'd1;
         end else if (r_state == S_DCLR) begin
            r_idx <= 10'd0;
         end else if (r_state == S_DPOLL && w_next == S_DXFER) begin
            r_idx <= r_idx + 10'd1;
         end
         if (r_state == S_DPOLL && w_next == S_CXFER)      r_c <= 1'b0;
         else if (r_state == S_CPOLL && w_next == S_CXFER) r_c <= 1'b1;
         if (w_next == S_FIN) r_status <= w_fin_st;
      end
   end

   // Engine register accesses, buffer strobe and handshake outputs per state.
   always_comb begin
      sd_cs   = 1'b0;
      sd_we   = 1'b0;
      sd_adr  = 4'd0;
      sd_sel  = 4'b0000;
      sd_d    = 32'h0000_0000;
      buf_we  = 1'b0;
      buf_adr = 10'd0;
      buf_d   = 8'h00;
      done    = 1'b0;
      busy    = (r_state != S_IDLE) && (r_state != S_FIN);
      case (r_state)
         S_TCLR, S_DCLR: begin
            sd_cs  = 1'b1;
            sd_we  = 1'b1;
            sd_adr = 4'd1;
            sd_sel = 4'b0011;
         end
         S_TXFER, S_DXFER, S_CXFER: begin
            sd_cs  = 1'b1;
            sd_we  = 1'b1;
            sd_sel = 4'b0011;
            sd_d   = XFER_D;
         end
         S_TPOLL, S_CPOLL: sd_cs = 1'b1;
         S_DPOLL: begin
            sd_cs   = 1'b1;
            buf_adr = r_idx;
            buf_d   = w_byte;
            if (w_rdy && !abort) buf_we = 1'b1;
            else                 buf_we = 1'b0;
         end
         S_CCHK: begin
            sd_cs  = 1'b1;
            sd_adr = 4'd1;
         end
         S_FIN:   done = 1'b1;
         default: done = 1'b0;
      endcase
   end
endmodule
